// File: rtl/cam_frame_writer.sv
// OV7670 capture back end: decimates the pixel stream, packs kept pixels to 12 bits and
// writes them to frame RAM via a small FIFO. Define CAM_FRAME_WRITER_GRAYSCALE_EN for grey output.
module cam_frame_writer #(
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int DEC_SHIFT  = 1,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        pixel_x,
  input  logic [8:0]        pixel_y,
  input  logic [15:0]       pixel_data,
  input  logic              pixel_valid,
  input  logic              frame_done,
  input  logic              capture_en,
  input  logic              ram_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [11:0]       ram_data,
  output logic [7:0]        frame_count,
  output logic              capturing,
  output logic              overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_W + 12;
  localparam logic [9:0] XMASK = 10'((1 << DEC_SHIFT) - 1);
  localparam logic [8:0] YMASK = 9'((1 << DEC_SHIFT) - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DRAIN} state_e;

  state_e            state_q;
  logic              capturing_q, overflow_q, ram_we_q;
  logic [7:0]        frame_count_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [11:0]       ram_data_q;

  logic              s1_vld_q;
  logic [9:0]        s1_x_q;
  logic [8:0]        s1_y_q;
  logic [11:0]       s1_rgb_q;

  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [PW:0]       wr_q, rd_q;

  logic        sof, accept, keep, empty, full, pop, push, drop;
  logic [9:0]  xd;
  logic [8:0]  yd;
  logic [11:0] color;
  logic [31:0] addr_full;
  logic [EW-1:0] head;

  assign sof    = pixel_valid && (pixel_x == 10'd0) && (pixel_y == 9'd0);
  assign accept = pixel_valid && ((state_q == CAPTURE) || ((state_q == WAIT_SOF) && sof));
  assign xd     = pixel_x >> DEC_SHIFT;
  assign yd     = pixel_y >> DEC_SHIFT;
  assign keep   = accept && ((pixel_x & XMASK) == 10'd0) && ((pixel_y & YMASK) == 9'd0)
                  && (32'(xd) < IMG_W) && (32'(yd) < IMG_H);

`ifdef CAM_FRAME_WRITER_GRAYSCALE_EN
  // Luma approximation 2R+G+B keeps within 8 bits (max 156); top nibble is the grey level.
  logic [7:0] gsum;
  logic       unused_gsum;
  assign gsum        = {2'b0, pixel_data[15:11], 1'b0} + {2'b0, pixel_data[10:5]} + {3'b0, pixel_data[4:0]};
  assign color       = {3{gsum[7:4]}};
  assign unused_gsum = ^gsum[3:0];
`else
  logic unused_pix;
  assign color      = {pixel_data[15:12], pixel_data[10:7], pixel_data[4:1]};
  assign unused_pix = ^{pixel_data[11], pixel_data[5], pixel_data[0]};
`endif

  assign addr_full = 32'(s1_y_q) * 32'(IMG_W) + 32'(s1_x_q);

  logic unused_addr;
  assign unused_addr = ^addr_full[31:ADDR_W];

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign pop   = !empty && ram_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push  = s1_vld_q && (!full || pop);
  assign drop  = s1_vld_q && full && !pop;
  assign head  = mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[PW-1:0]] <= {addr_full[ADDR_W-1:0], s1_rgb_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_rgb_q   <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      s1_vld_q <= keep;
      if (keep) begin
        s1_x_q   <= xd;
        s1_y_q   <= yd;
        s1_rgb_q <= color;
      end
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (drop) overflow_q <= 1'b1;
      ram_we_q <= pop;
      if (pop) {ram_addr_q, ram_data_q} <= head;
    end
  end

  // Leaving DRAIN also waits for stage 1, so a pixel that arrived with frame_done is written first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      capturing_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      case (state_q)
        IDLE:     if (capture_en) state_q <= WAIT_SOF;
        WAIT_SOF: if (sof) begin
          state_q     <= CAPTURE;
          capturing_q <= 1'b1;
        end
        CAPTURE:  if (frame_done) begin
          state_q     <= DRAIN;
          capturing_q <= 1'b0;
        end
        DRAIN:    if (empty && !s1_vld_q) begin
          frame_count_q <= frame_count_q + 8'd1;
          state_q       <= capture_en ? WAIT_SOF : IDLE;
        end
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data    = ram_data_q;
  assign frame_count = frame_count_q;
  assign capturing   = capturing_q;
  assign overflow    = overflow_q;
endmodule
